aes_axis_blk_bridge: RTL



---
 rtl/aes_axis_blk_bridge_pkg.sv | 8 +
 rtl/aes_axis_unpack.sv | 51 +++++
 rtl/aes_axis_blk_bridge.sv | 105 ++++++++++
 3 files changed

// File: rtl/aes_axis_blk_bridge_pkg.sv
// aes_axis_blk_bridge_pkg: shared AES block geometry and slave FSM states
package aes_axis_blk_bridge_pkg;
  localparam int NB = 4;
  localparam int WORD_S = 32;
  localparam int BLK_W = NB * WORD_S;
  localparam int CMD_W = 32;
  typedef enum logic {S_CMD, S_DATA} state_t;
endpackage

// File: rtl/aes_axis_unpack.sv
// aes_axis_unpack: holds one result block and streams it out MSB slice first
module aes_axis_unpack
  import aes_axis_blk_bridge_pkg::*;
#(
  parameter int W = 32,
  parameter int BLK = BLK_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BLK-1:0] in_data,
  input  logic           in_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           m_last
);
  localparam int BEATS = BLK / W;
  localparam int CW = $clog2(BEATS + 1);
  logic [BLK-1:0] sreg;
  logic           held_last;
  logic [CW-1:0]  beat;
  logic           fire;
  logic           end_beat;
  always_comb begin
    end_beat = beat == CW'(BEATS - 1);
    fire = m_valid && m_ready;
    in_ready = en && (!m_valid || (fire && end_beat));
    m_data = sreg[BLK-1 -: W];
    m_last = m_valid && held_last && end_beat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      sreg <= '0;
      held_last <= 1'b0;
      beat <= '0;
    end else if (in_valid && in_ready) begin
      m_valid <= 1'b1;
      sreg <= in_data;
      held_last <= in_last;
      beat <= '0;
    end else if (fire) begin
      m_valid <= !end_beat;
      sreg <= sreg << W;
      beat <= end_beat ? '0 : beat + CW'(1);
    end
  end
endmodule

// File: rtl/aes_axis_blk_bridge.sv
// aes_axis_blk_bridge: packs AXI-stream beats into AES blocks and unpacks results
module aes_axis_blk_bridge
  import aes_axis_blk_bridge_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int BLK_WIDTH = BLK_W,
  parameter int CMD_WIDTH = CMD_W
) (
  input  logic                            axis_aclk,
  input  logic                            axis_aresetn,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  output logic                            blk_in_valid,
  input  logic                            blk_in_ready,
  output logic [BLK_WIDTH-1:0]            blk_in_data,
  output logic                            blk_in_last,
  output logic [CMD_WIDTH-1:0]            blk_in_cmd,
  input  logic                            blk_out_valid,
  output logic                            blk_out_ready,
  input  logic [BLK_WIDTH-1:0]            blk_out_data,
  input  logic                            blk_out_last,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic                            err_short,
  output logic                            err_partial
);
  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int BEATS = BLK_WIDTH / W;
  localparam int CW = $clog2(BEATS + 1);
  state_t               state;
  logic                 live;
  logic [BLK_WIDTH-1:0] pack_reg;
  logic [BLK_WIDTH-1:0] pack_nxt;
  logic [BLK_WIDTH-1:0] pack_blk;
  logic [CW-1:0]        beat_cnt;
  logic                 full;
  logic                 at_end;
  logic                 done;
  logic                 take;
  logic                 unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;
  assign m00_axis_tstrb = '1;
  // live keeps every handshake output low until the first clock after reset
  always_comb begin
    full = blk_in_valid && !blk_in_ready;
    at_end = beat_cnt == CW'(BEATS - 1);
    done = state == S_DATA && (at_end || s00_axis_tlast);
    s00_axis_tready = live && !(full && (state == S_CMD || done));
    take = s00_axis_tvalid && s00_axis_tready;
    pack_nxt = (pack_reg << W) | BLK_WIDTH'(s00_axis_tdata);
    pack_blk = pack_nxt << (W * (BEATS - 1 - int'(beat_cnt)));
  end
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= S_CMD;
      live <= 1'b0;
      pack_reg <= '0;
      beat_cnt <= '0;
      blk_in_valid <= 1'b0;
      blk_in_data <= '0;
      blk_in_last <= 1'b0;
      blk_in_cmd <= '0;
      err_short <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      live <= 1'b1;
      err_short <= take && state == S_CMD && s00_axis_tlast;
      err_partial <= take && done && s00_axis_tlast && !at_end;
      if (blk_in_ready) blk_in_valid <= 1'b0;
      if (take && state == S_CMD) begin
        blk_in_cmd <= s00_axis_tdata[CMD_WIDTH-1:0];
        state <= s00_axis_tlast ? S_CMD : S_DATA;
      end
      if (take && state == S_DATA) begin
        pack_reg <= done ? '0 : pack_nxt;
        beat_cnt <= done ? '0 : beat_cnt + CW'(1);
        if (done) begin
          blk_in_valid <= 1'b1;
          blk_in_data <= pack_blk;
          blk_in_last <= s00_axis_tlast;
        end
        if (s00_axis_tlast) state <= S_CMD;
      end
    end
  end
  aes_axis_unpack #(.W(W), .BLK(BLK_WIDTH)) u_unpack (
    .clk      (axis_aclk),
    .rst_n    (axis_aresetn),
    .en       (live),
    .in_valid (blk_out_valid),
    .in_ready (blk_out_ready),
    .in_data  (blk_out_data),
    .in_last  (blk_out_last),
    .m_valid  (m00_axis_tvalid),
    .m_ready  (m00_axis_tready),
    .m_data   (m00_axis_tdata),
    .m_last   (m00_axis_tlast)
  );
endmodule
